// File: rtl/simon_data_in_pkg.sv
// Shared SIMON definitions for the byte-serial input stage: word/key sizing,
// packet framing sizes, FSM state codes and info-byte bit positions.
package simon_data_in_pkg;

  localparam int SIMON_N = 16;
  localparam int SIMON_M = 4;

  localparam int BLK_BYTES = 2 * SIMON_N / 8;
  localparam int KEY_BYTES = SIMON_M * SIMON_N / 8;

  typedef logic [2:0] state_t;

  localparam state_t INFO  = 3'd0;
  localparam state_t COUNT = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t KEY   = 3'd3;
  localparam state_t HOLD  = 3'd4;

  localparam int KP_BIT  = 0;
  localparam int DEC_BIT = 1;

endpackage

// File: rtl/simon_data_in_shift.sv
// Byte-wide shift-in register: each enabled byte enters at the LSB end, so the
// first byte of a sequence ends up in the most significant byte.
module simon_shift_in #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   byteIn,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-9:0], byteIn};
    end
  end

endmodule

// File: rtl/simon_data_in.sv
// Packet deserializer ahead of the SIMON core: collects info, count, block and
// optional key bytes, then holds them under dataVALID until readDATA.
module simon_data_in
  import simon_data_in_pkg::*;
#(
  parameter int N = simon_data_in_pkg::SIMON_N,
  parameter int M = simon_data_in_pkg::SIMON_M
) (
  input  logic                clk,
  input  logic                nR,
  input  logic [7:0]          byteIN,
  input  logic                byteVALID,
  output logic                byteREADY,
  output logic [7:0]          infoIN,
  output logic [7:0]          countIN,
  output logic [1:0][N-1:0]   inDATA,
  output logic [M-1:0][N-1:0] keyIN,
  output logic                newKEY,
  output logic                dataVALID,
  input  logic                readDATA
);

  localparam int BlkW     = 2 * N;
  localparam int KeyW     = M * N;
  localparam int BlkBytes = BlkW / 8;
  localparam int KeyBytes = KeyW / 8;
  localparam int CW       = $clog2(KeyBytes) + 1;

  localparam logic [CW-1:0] BlkLast = CW'(BlkBytes - 1);
  localparam logic [CW-1:0] KeyLast = CW'(KeyBytes - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            xfer;
  logic [BlkW-1:0] blkQ;
  logic [KeyW-1:0] keyStage;
  logic [KeyW-1:0] keyNext;

  assign xfer    = byteVALID & byteREADY;
  assign inDATA  = blkQ;
  // The final key byte is folded in on the fly so keyIN updates on that edge.
  assign keyNext = {keyStage[KeyW-9:0], byteIN};

  simon_shift_in #(.W(BlkW)) uBlk (
    .clk    (clk),
    .clr    (!nR),
    .en     (xfer && (state == DATA)),
    .byteIn (byteIN),
    .q      (blkQ)
  );

  simon_shift_in #(.W(KeyW)) uKey (
    .clk    (clk),
    .clr    (!nR),
    .en     (xfer && (state == KEY)),
    .byteIn (byteIN),
    .q      (keyStage)
  );

  always_ff @(posedge clk) begin
    if (!nR) begin
      state     <= INFO;
      cnt       <= '0;
      byteREADY <= 1'b0;
      dataVALID <= 1'b0;
      newKEY    <= 1'b0;
      infoIN    <= '0;
      countIN   <= '0;
      keyIN     <= '0;
    end else begin
      case (state)
        INFO: begin
          byteREADY <= 1'b1;
          if (xfer) begin
            infoIN <= byteIN;
            state  <= COUNT;
          end
        end
        COUNT: begin
          if (xfer) begin
            countIN <= byteIN;
            cnt     <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (cnt == BlkLast) begin
              cnt <= '0;
              if (infoIN[KP_BIT]) begin
                state <= KEY;
              end else begin
                state     <= HOLD;
                byteREADY <= 1'b0;
                dataVALID <= 1'b1;
                newKEY    <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        KEY: begin
          if (xfer) begin
            if (cnt == KeyLast) begin
              keyIN     <= keyNext;
              cnt       <= '0;
              state     <= HOLD;
              byteREADY <= 1'b0;
              dataVALID <= 1'b1;
              newKEY    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (readDATA) begin
            dataVALID <= 1'b0;
            newKEY    <= 1'b0;
            byteREADY <= 1'b1;
            state     <= INFO;
          end
        end
        default: begin
          state     <= INFO;
          byteREADY <= 1'b1;
          dataVALID <= 1'b0;
          newKEY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_data_in.sv
// Bench for simon_data_in: directed scenarios plus randomized packets checked
// against a packet-level reference model (byte lists -> expected outputs).
module tb_simon_data_in;

  localparam int N = 16;
  localparam int M = 4;

  logic                clk = 1'b0;
  logic                nR = 1'b0;
  logic [7:0]          byteIN = 8'h00;
  logic                byteVALID = 1'b0;
  logic                readDATA = 1'b0;
  logic                byteREADY;
  logic [7:0]          infoIN;
  logic [7:0]          countIN;
  logic [1:0][N-1:0]   inDATA;
  logic [M-1:0][N-1:0] keyIN;
  logic                newKEY;
  logic                dataVALID;

  simon_data_in #(.N(N), .M(M)) dut (
    .clk       (clk),
    .nR        (nR),
    .byteIN    (byteIN),
    .byteVALID (byteVALID),
    .byteREADY (byteREADY),
    .infoIN    (infoIN),
    .countIN   (countIN),
    .inDATA    (inDATA),
    .keyIN     (keyIN),
    .newKEY    (newKEY),
    .dataVALID (dataVALID),
    .readDATA  (readDATA)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nPass = 0;
  logic [7:0]  pkt[$];
  logic [63:0] mKey = '0;
  logic [31:0] heldBlk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buildPkt(input bit kp);
    logic [7:0] info;
    pkt.delete();
    info = 8'($urandom);
    info[0] = kp;
    pkt.push_back(info);
    pkt.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
    if (kp) for (int i = 0; i < 8; i++) pkt.push_back(8'($urandom));
  endtask

  // gapMode: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps
  task automatic sendPacket(input int n, input int gapMode);
    int idx = 0;
    int cyc = 0;
    bit take;
    while (idx < n && cyc < 400) begin
      byteIN = pkt[idx];
      case (gapMode)
        0:       byteVALID = 1'b1;
        1:       byteVALID = (cyc % 2 == 0);
        default: byteVALID = ($urandom_range(0, 3) != 0);
      endcase
      take = byteVALID && byteREADY;
      if (take && idx == n - 1 && n == pkt.size()) chk("vldEarly", 64'(dataVALID), 64'd0);
      tick();
      if (take) idx++;
      cyc++;
    end
    byteVALID = 1'b0;
    if (idx < n) chk("timeout", 64'd0, 64'd1);
  endtask

  // Expected outputs come straight from the byte list: block = bytes 2..5 in
  // order, key = bytes 6..13 when KP is set, otherwise the previous key.
  task automatic checkPacket(input string tag);
    logic [31:0] eb;
    logic [63:0] ek;
    eb = '0;
    for (int i = 2; i < 6; i++) eb = {eb[23:0], pkt[i]};
    if (pkt[0][0]) begin
      ek = '0;
      for (int i = 6; i < 14; i++) ek = {ek[55:0], pkt[i]};
      mKey = ek;
    end
    heldBlk = eb;
    chk({tag, ".latency"}, 64'(dataVALID), 64'd1);
    chk({tag, ".rdyHold"}, 64'(byteREADY), 64'd0);
    chk({tag, ".info"}, 64'(infoIN), 64'(pkt[0]));
    chk({tag, ".count"}, 64'(countIN), 64'(pkt[1]));
    chk({tag, ".data"}, 64'(inDATA), 64'(eb));
    chk({tag, ".key"}, 64'(keyIN), mKey);
    chk({tag, ".newKey"}, 64'(newKEY), 64'(pkt[0][0]));
  endtask

  task automatic accept(input string tag);
    readDATA = 1'b1;
    tick();
    readDATA = 1'b0;
    chk({tag, ".vldDrop"}, 64'(dataVALID), 64'd0);
    chk({tag, ".newKeyDrop"}, 64'(newKEY), 64'd0);
    chk({tag, ".rdyBack"}, 64'(byteREADY), 64'd1);
  endtask

  initial begin
    int waitCyc;
    // Reset values
    nR = 1'b0;
    repeat (3) tick();
    chk("rst.ready", 64'(byteREADY), 64'd0);
    chk("rst.valid", 64'(dataVALID), 64'd0);
    chk("rst.newKey", 64'(newKEY), 64'd0);
    chk("rst.info", 64'(infoIN), 64'd0);
    chk("rst.count", 64'(countIN), 64'd0);
    chk("rst.data", 64'(inDATA), 64'd0);
    chk("rst.key", 64'(keyIN), 64'd0);
    nR = 1'b1;
    tick();
    chk("rst.readyRise", 64'(byteREADY), 64'd1);

    // Directed KP=1 packet with readDATA held high throughout
    pkt = '{8'h01, 8'h07, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    readDATA = 1'b1;
    sendPacket(pkt.size(), 0);
    checkPacket("kp1");
    chk("kp1.dataConst", 64'(inDATA), 64'hA1B2C3D4);
    chk("kp1.keyConst", 64'(keyIN), 64'h0011223344556677);
    tick();
    readDATA = 1'b0;
    chk("kp1.oneCycle", 64'(dataVALID), 64'd0);

    // Directed KP=0 packet keeps the key
    pkt = '{8'h00, 8'h08, 8'h12, 8'h34, 8'h56, 8'h78};
    sendPacket(pkt.size(), 0);
    checkPacket("kp0");
    chk("kp0.keyKept", 64'(keyIN), 64'h0011223344556677);

    // Backpressure: next info byte offered while held
    buildPkt(1'b0);
    byteVALID = 1'b1;
    byteIN = pkt[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.ready", 64'(byteREADY), 64'd0);
      chk("bp.valid", 64'(dataVALID), 64'd1);
      chk("bp.data", 64'(inDATA), 64'(heldBlk));
    end
    readDATA = 1'b1;
    tick();
    readDATA = 1'b0;
    chk("bp.vldDrop", 64'(dataVALID), 64'd0);
    sendPacket(pkt.size(), 0);
    checkPacket("bpNext");
    accept("bpNext");

    // Gapped KP=1 packet
    pkt = '{8'h01, 8'h07, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    sendPacket(pkt.size(), 1);
    checkPacket("gap");
    accept("gap");

    // Idle readDATA pulse is ignored
    readDATA = 1'b1;
    tick();
    readDATA = 1'b0;
    chk("idle.valid", 64'(dataVALID), 64'd0);
    chk("idle.ready", 64'(byteREADY), 64'd1);

    // Reset after the third key byte
    buildPkt(1'b1);
    sendPacket(9, 0);
    nR = 1'b0;
    tick();
    chk("midRst.ready", 64'(byteREADY), 64'd0);
    chk("midRst.valid", 64'(dataVALID), 64'd0);
    chk("midRst.info", 64'(infoIN), 64'd0);
    chk("midRst.count", 64'(countIN), 64'd0);
    chk("midRst.data", 64'(inDATA), 64'd0);
    chk("midRst.key", 64'(keyIN), 64'd0);
    chk("midRst.newKey", 64'(newKEY), 64'd0);
    mKey = '0;
    nR = 1'b1;
    tick();
    chk("midRst.readyRise", 64'(byteREADY), 64'd1);
    buildPkt(1'b0);
    sendPacket(pkt.size(), 0);
    checkPacket("postRst");
    accept("postRst");

    // Randomized packets with random gaps and accept delays
    for (int p = 0; p < 30; p++) begin
      buildPkt(1'($urandom));
      sendPacket(pkt.size(), int'($urandom_range(0, 2)));
      checkPacket("rnd");
      waitCyc = int'($urandom_range(0, 3));
      for (int w = 0; w < waitCyc; w++) begin
        tick();
        chk("rnd.holdValid", 64'(dataVALID), 64'd1);
        chk("rnd.holdData", 64'(inDATA), 64'(heldBlk));
      end
      accept("rnd");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
